// File: rtl/gpio_bank_ctrl_if.sv
// Host register-access port for gpio_bank_ctrl.
//   req_valid/req_ready : request handshake (host -> controller)
//   req_write           : 1 = write, 0 = read
//   req_addr            : {region[2:0], word[4:0]}
//   req_wdata           : write data
//   rsp_valid/rsp_ready : response handshake (controller -> host)
//   rsp_rdata           : read data, 0 for writes and errors
//   rsp_err             : illegal address or access type
interface gpio_bank_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// GPIO bank register controller.
// Serialises 32-bit register accesses from a single valid/ready host port
// (IDLE -> EXEC -> RESP) onto a NUM_GPIO-wide pin bank: output data, output
// enable, synchronised inputs and per-pin rising-edge interrupt status.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus             : host request/response port (slave side)
//   gpio_in_data    : raw asynchronous pad inputs
//   gpio_out_data   : output values
//   gpio_out_enable : output driver enables
//   irq             : registered level interrupt, |(IRQ_STS & IRQ_EN)
// Regions (addr[7:5]): 0 OUT, 1 OE, 2 IN (RO), 3 SET (WO), 4 CLR (WO),
//   5 IRQ_EN, 6 IRQ_STS (W1C), 7 reserved. addr[4:0] selects a 32-bit word.
module gpio_bank_ctrl #(
  parameter int unsigned NUM_GPIO    = 256,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  gpio_bank_ctrl_if.slave     bus,
  input  logic [NUM_GPIO-1:0] gpio_in_data,
  output logic [NUM_GPIO-1:0] gpio_out_data,
  output logic [NUM_GPIO-1:0] gpio_out_enable,
  output logic                irq
);

  localparam int unsigned NumWords = NUM_GPIO / 32;
  localparam int unsigned ArmCount = SYNC_STAGES + 1;
  localparam int unsigned ArmW     = $clog2(ArmCount + 1);

  localparam logic [2:0] RegOut    = 3'd0;
  localparam logic [2:0] RegOe     = 3'd1;
  localparam logic [2:0] RegIn     = 3'd2;
  localparam logic [2:0] RegSet    = 3'd3;
  localparam logic [2:0] RegClr    = 3'd4;
  localparam logic [2:0] RegIrqEn  = 3'd5;
  localparam logic [2:0] RegIrqSts = 3'd6;
  localparam logic [2:0] RegRsvd   = 3'd7;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [NUM_GPIO-1:0] out_q, out_d;
  logic [NUM_GPIO-1:0] oe_q, oe_d;
  logic [NUM_GPIO-1:0] en_q, en_d;
  logic [NUM_GPIO-1:0] sts_q, sts_d;
  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] prev_q;
  logic [ArmW-1:0]     arm_q;
  logic                irq_q;

  logic [NUM_GPIO-1:0] sync, rise, sel_mask, wdata_ext, w1c;
  logic [2:0]          region;
  logic [4:0]          word;
  logic                word_ok, acc_err, exec_wr, armed;
  logic [31:0]         rd_word;

  assign sync   = sync_q[SYNC_STAGES-1];
  // Edge detection stays masked until the synchroniser and prev stage hold
  // real post-reset samples, so pins already high at reset raise nothing.
  assign armed  = (arm_q == ArmW'(ArmCount));
  assign rise   = sync & ~prev_q & {NUM_GPIO{armed}};

  assign region  = addr_q[ADDR_W-1 -: 3];
  assign word    = addr_q[4:0];
  assign word_ok = (32'(word) < NumWords);
  assign acc_err = (region == RegRsvd) || !word_ok ||
                   (wr_q && (region == RegIn)) ||
                   (!wr_q && ((region == RegSet) || (region == RegClr)));
  assign exec_wr = (state_q == StExec) && wr_q && !acc_err;

  // Word select: lane mask, write data placed in its lane, and read mux.
  always_comb begin
    sel_mask  = '0;
    wdata_ext = '0;
    rd_word   = '0;
    for (int w = 0; w < int'(NumWords); w++) begin
      if (word_ok && (word == 5'(w))) begin
        sel_mask[32*w +: 32]  = '1;
        wdata_ext[32*w +: 32] = wdata_q;
        case (region)
          RegOut:    rd_word = out_q[32*w +: 32];
          RegOe:     rd_word = oe_q[32*w +: 32];
          RegIn:     rd_word = sync[32*w +: 32];
          RegIrqEn:  rd_word = en_q[32*w +: 32];
          RegIrqSts: rd_word = sts_q[32*w +: 32];
          default:   rd_word = '0;
        endcase
      end
    end
  end

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    en_d  = en_q;
    w1c   = '0;
    if (exec_wr) begin
      case (region)
        RegOut:    out_d = (out_q & ~sel_mask) | wdata_ext;
        RegOe:     oe_d  = (oe_q & ~sel_mask) | wdata_ext;
        RegSet:    out_d = out_q | wdata_ext;
        RegClr:    out_d = out_q & ~wdata_ext;
        RegIrqEn:  en_d  = (en_q & ~sel_mask) | wdata_ext;
        RegIrqSts: w1c   = wdata_ext;
        default:   ;
      endcase
    end
    // A new edge in the same cycle as a W1C keeps the bit set.
    sts_d = (sts_q & ~w1c) | (rise & en_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q <= '0;
      arm_q  <= '0;
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      sts_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q[0] <= gpio_in_data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync;
      if (!armed) arm_q <= arm_q + ArmW'(1);
      out_q  <= out_d;
      oe_q   <= oe_d;
      en_q   <= en_d;
      sts_q  <= sts_d;
      irq_q  <= |(sts_q & en_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            wr_q        <= bus.req_write;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= StExec;
          end
        end
        StExec: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= (wr_q || acc_err) ? 32'h0 : rd_word;
          rsp_err_q   <= acc_err;
          state_q     <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign gpio_out_data   = out_q;
  assign gpio_out_enable = oe_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
module tb_gpio_bank_ctrl;
  localparam int unsigned NG   = 256;
  localparam int unsigned SYNC = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NG-1:0] gpio_in_data = '1;
  logic [NG-1:0] gpio_out_data;
  logic [NG-1:0] gpio_out_enable;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  rsp_t          exp_q[$];
  logic [NG-1:0] out_m = '0;
  logic [NG-1:0] oe_m  = '0;

  gpio_bank_ctrl_if #(.ADDR_W(8)) bus ();

  gpio_bank_ctrl #(
    .NUM_GPIO   (NG),
    .SYNC_STAGES(SYNC),
    .ADDR_W     (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .gpio_in_data   (gpio_in_data),
    .gpio_out_data  (gpio_out_data),
    .gpio_out_enable(gpio_out_enable),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [NG-1:0] obs, input logic [NG-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One host access. Expected response is queued when the request is driven
  // and popped when rsp_valid appears. hold = cycles rsp_ready is withheld.
  task automatic xact(input string tag, input logic wr, input logic [2:0] region,
                      input logic [4:0] word, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    rsp_t got;
    rsp_t exp;
    int   edges;
    exp_q.push_back('{rdata: exp_rd, err: exp_err});
    if (wr && !exp_err) begin
      case (region)
        3'd0: out_m[32*word +: 32] = wd;
        3'd1: oe_m[32*word +: 32]  = wd;
        3'd3: out_m[32*word +: 32] = out_m[32*word +: 32] | wd;
        3'd4: out_m[32*word +: 32] = out_m[32*word +: 32] & ~wd;
        default: ;
      endcase
    end
    check({tag, " req_ready"}, NG'(bus.req_ready), NG'(1'b1));
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = {region, word};
    bus.req_wdata = wd;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      // Scramble fields after the handshake; they must not be resampled.
      bus.req_valid = 1'b0;
      bus.req_write = ~wr;
      bus.req_addr  = 8'hFF;
      bus.req_wdata = 32'hDEAD_BEEF;
    end while (!bus.rsp_valid && edges < 20);
    check({tag, " latency"}, NG'(edges), NG'(2));
    exp = exp_q.pop_front();
    got = '{rdata: bus.rsp_rdata, err: bus.rsp_err};
    check({tag, " rdata"}, NG'(got.rdata), NG'(exp.rdata));
    check({tag, " err"}, NG'(got.err), NG'(exp.err));
    check({tag, " out_data"}, gpio_out_data, out_m);
    check({tag, " out_en"}, gpio_out_enable, oe_m);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        // Request offered outside IDLE must be ignored.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = {3'd0, 5'd3};
        bus.req_wdata = 32'h0;
      end
      tick(1);
      check({tag, " hold valid"}, NG'(bus.rsp_valid), NG'(1'b1));
      check({tag, " hold rdata"}, NG'(bus.rsp_rdata), NG'(exp.rdata));
      check({tag, " hold err"}, NG'(bus.rsp_err), NG'(exp.err));
      check({tag, " hold ready"}, NG'(bus.req_ready), NG'(1'b0));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick(1);
    bus.rsp_ready = 1'b0;
    check({tag, " rsp done"}, NG'(bus.rsp_valid), NG'(1'b0));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset with every pad input held high.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("rst out_data", gpio_out_data, '0);
    check("rst out_en", gpio_out_enable, '0);
    check("rst irq", NG'(irq), NG'(1'b0));
    check("rst rsp_valid", NG'(bus.rsp_valid), NG'(1'b0));
    check("rst rsp_rdata", NG'(bus.rsp_rdata), NG'(32'h0));
    // Enable IRQs on word 0 immediately; the high-at-reset pins must not latch.
    xact("en w0", 1'b1, 3'd5, 5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    xact("rd out w0", 1'b0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b0, 0);
    xact("rd sts w0 arm", 1'b0, 3'd6, 5'd0, 32'h0, 32'h0, 1'b0, 0);
    check("arm irq", NG'(irq), NG'(1'b0));
    xact("rd in w1 high", 1'b0, 3'd2, 5'd1, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
    xact("en w0 off", 1'b1, 3'd5, 5'd0, 32'h0, 32'h0, 1'b0, 0);

    // Output/enable datapath.
    xact("oe w3", 1'b1, 3'd1, 5'd3, 32'hFFFF_0000, 32'h0, 1'b0, 0);
    xact("out w3", 1'b1, 3'd0, 5'd3, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    xact("set w3", 1'b1, 3'd3, 5'd3, 32'h0000_000F, 32'h0, 1'b0, 0);
    xact("clr w3", 1'b1, 3'd4, 5'd3, 32'hA000_0000, 32'h0, 1'b0, 0);
    check("out w3 pins", NG'(gpio_out_data[127:96]), NG'(32'h05A5_A5AF));
    check("oe w3 pins", NG'(gpio_out_enable[127:96]), NG'(32'hFFFF_0000));
    xact("rd out w3", 1'b0, 3'd0, 5'd3, 32'h0, 32'h05A5_A5AF, 1'b0, 0);
    xact("rd oe w3", 1'b0, 3'd1, 5'd3, 32'h0, 32'hFFFF_0000, 1'b0, 0);

    // Input synchroniser: a change is not visible before SYNC stages.
    gpio_in_data = '0;
    tick(5);
    gpio_in_data[40] = 1'b1;
    xact("rd in w1 early", 1'b0, 3'd2, 5'd1, 32'h0, 32'h0, 1'b0, 0);
    xact("rd in w1", 1'b0, 3'd2, 5'd1, 32'h0, 32'h0000_0100, 1'b0, 0);
    xact("rd sts w1", 1'b0, 3'd6, 5'd1, 32'h0, 32'h0, 1'b0, 0);
    check("irq masked pin", NG'(irq), NG'(1'b0));

    // Rising edge on pin 255 with IRQ enabled.
    xact("en w7", 1'b1, 3'd5, 5'd7, 32'h8000_0000, 32'h0, 1'b0, 0);
    gpio_in_data[255] = 1'b1;
    tick(SYNC + 2);
    check("irq set", NG'(irq), NG'(1'b1));
    gpio_in_data[255] = 1'b0;
    xact("rd sts w7", 1'b0, 3'd6, 5'd7, 32'h0, 32'h8000_0000, 1'b0, 0);
    xact("rd en w7", 1'b0, 3'd5, 5'd7, 32'h0, 32'h8000_0000, 1'b0, 0);
    xact("w1c w7", 1'b1, 3'd6, 5'd7, 32'h8000_0000, 32'h0, 1'b0, 0);
    check("irq cleared", NG'(irq), NG'(1'b0));
    xact("rd sts w7 clr", 1'b0, 3'd6, 5'd7, 32'h0, 32'h0, 1'b0, 0);
    // New edge lands on the W1C execute cycle: the bit must survive.
    gpio_in_data[255] = 1'b1;
    tick(SYNC - 1);
    xact("w1c race", 1'b1, 3'd6, 5'd7, 32'h8000_0000, 32'h0, 1'b0, 0);
    check("irq race", NG'(irq), NG'(1'b1));
    xact("rd sts race", 1'b0, 3'd6, 5'd7, 32'h0, 32'h8000_0000, 1'b0, 0);
    xact("en w7 off", 1'b1, 3'd5, 5'd7, 32'h0, 32'h0, 1'b0, 0);
    check("irq en off", NG'(irq), NG'(1'b0));
    xact("rd sts en off", 1'b0, 3'd6, 5'd7, 32'h0, 32'h8000_0000, 1'b0, 0);
    xact("en w7 on", 1'b1, 3'd5, 5'd7, 32'h8000_0000, 32'h0, 1'b0, 0);
    check("irq en on", NG'(irq), NG'(1'b1));

    // Illegal accesses: error response, zero data, no state change.
    xact("rd rsvd", 1'b0, 3'd7, 5'd0, 32'h0, 32'h0, 1'b1, 0);
    xact("wr rsvd", 1'b1, 3'd7, 5'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    xact("rd out w8", 1'b0, 3'd0, 5'd8, 32'h0, 32'h0, 1'b1, 0);
    xact("wr out w8", 1'b1, 3'd0, 5'd8, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    xact("wr in w1", 1'b1, 3'd2, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    xact("rd set w3", 1'b0, 3'd3, 5'd3, 32'h0, 32'h0, 1'b1, 0);
    xact("rd clr w3", 1'b0, 3'd4, 5'd3, 32'h0, 32'h0, 1'b1, 0);
    xact("rd sts w7 err", 1'b0, 3'd6, 5'd7, 32'h0, 32'h8000_0000, 1'b0, 0);

    // Response backpressure with an ignored request during RESP.
    xact("hold oe w3", 1'b0, 3'd1, 5'd3, 32'h0, 32'hFFFF_0000, 1'b0, 5);
    xact("rd out after hold", 1'b0, 3'd0, 5'd3, 32'h0, 32'h05A5_A5AF, 1'b0, 0);

    // Reset while a write is executing: dropped, no response.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = {3'd0, 5'd3};
    bus.req_wdata = 32'hFFFF_FFFF;
    tick(1);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    out_m = '0;
    oe_m  = '0;
    check("mid rst rsp_valid", NG'(bus.rsp_valid), NG'(1'b0));
    check("mid rst out", gpio_out_data, '0);
    check("mid rst oe", gpio_out_enable, '0);
    check("mid rst irq", NG'(irq), NG'(1'b0));
    check("mid rst ready", NG'(bus.req_ready), NG'(1'b1));
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("mid rst no rsp", NG'(bus.rsp_valid), NG'(1'b0));
    end
    xact("rd out w3 post rst", 1'b0, 3'd0, 5'd3, 32'h0, 32'h0, 1'b0, 0);
    check("scoreboard empty", NG'(exp_q.size()), NG'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
